// File: rtl/alu_cmp_q_pkg.sv
// Shared RV32I types for the ALU/compare unit: opcodes, op enums, RS entry and CDB packet.
// The optional statistics counters in alu_cmp_q are enabled by defining ALU_CMP_Q_STATS_EN.
package alu_cmp_q_pkg;

  localparam int PR_WIDTH  = 6;
  localparam int ROB_WIDTH = 4;

  localparam logic [6:0] op_b_lui   = 7'b0110111;
  localparam logic [6:0] op_b_auipc = 7'b0010111;
  localparam logic [6:0] op_b_jal   = 7'b1101111;
  localparam logic [6:0] op_b_jalr  = 7'b1100111;
  localparam logic [6:0] op_b_br    = 7'b1100011;
  localparam logic [6:0] op_b_load  = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;
  localparam logic [6:0] op_b_imm   = 7'b0010011;
  localparam logic [6:0] op_b_reg   = 7'b0110011;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3;

  typedef struct packed {
    logic       is_alu;
    logic [2:0] funct3;
  } alu_cmp_op_t;

  typedef struct packed {
    alu_cmp_op_t          op;
    logic [6:0]           opcode;
    logic [31:0]          imm_gen;
    logic [4:0]           arch_dest;
    logic [PR_WIDTH-1:0]  p_dest;
    logic [ROB_WIDTH-1:0] w_rob;
  } ReservationEntry_t;

  typedef struct packed {
    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] rob;
    logic [4:0]           arch_reg;
    logic [PR_WIDTH-1:0]  phys_reg;
    logic [31:0]          data;
    logic [31:0]          ps1_rdata;
    logic [31:0]          ps2_rdata;
    logic [31:0]          branch_imm;
    logic                 is_branch;
    logic                 is_jalr;
    logic                 is_store;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic [3:0]           mem_rmask;
    logic [3:0]           mem_wmask;
  } cdb_t;

  function automatic logic [31:0] shamt_only(input logic [31:0] v);
    return {27'b0, v[4:0]};
  endfunction

endpackage

// File: rtl/alu_cmp_exec.sv
// Combinational execute stage: operand select, ALU or compare, branch flags, CDB packing.
// No state; the result queue lives in alu_cmp_q.
module alu_cmp_exec
  import alu_cmp_q_pkg::*;
(
  input  ReservationEntry_t pkt,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output cdb_t              result
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        cmp_res;
  logic [31:0] res;

  // Operand select by opcode
  always_comb begin
    op_a = a;
    op_b = b;
    case (pkt.opcode)
      op_b_jal, op_b_jalr: begin
        op_a = pkt.imm_gen;
      end
      op_b_lui, op_b_auipc: begin
        op_a = 32'd0;
        op_b = pkt.imm_gen;
      end
      op_b_imm: begin
        op_b = pkt.imm_gen;
      end
      op_b_reg: begin
        if (pkt.op.is_alu && (pkt.op.funct3 == alu_srl || pkt.op.funct3 == alu_sra)) begin
          op_b = shamt_only(b);
        end else begin
          op_b = b;
        end
      end
      default: begin
        op_a = a;
      end
    endcase
  end

  // Integer ALU
  always_comb begin
    alu_res = 32'd0;
    case (pkt.op.funct3)
      alu_add: alu_res = op_a + op_b;
      alu_sll: alu_res = op_a << op_b[4:0];
      alu_sra: alu_res = 32'($signed(op_a) >>> op_b[4:0]);
      alu_sub: alu_res = op_a - op_b;
      alu_xor: alu_res = op_a ^ op_b;
      alu_srl: alu_res = op_a >> op_b[4:0];
      alu_or:  alu_res = op_a | op_b;
      alu_and: alu_res = op_a & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Comparator; unused funct3 encodings yield 0
  always_comb begin
    cmp_res = 1'b0;
    case (pkt.op.funct3)
      beq:     cmp_res = (op_a == op_b);
      bne:     cmp_res = (op_a != op_b);
      blt:     cmp_res = ($signed(op_a) < $signed(op_b));
      bge:     cmp_res = ($signed(op_a) >= $signed(op_b));
      bltu:    cmp_res = (op_a < op_b);
      bgeu:    cmp_res = (op_a >= op_b);
      default: cmp_res = 1'b0;
    endcase
  end

  // Result select and CDB packet assembly
  always_comb begin
    if (pkt.op.is_alu) begin
      res = alu_res;
    end else begin
      res = {31'b0, cmp_res};
    end
    result            = '0;
    result.cdb_valid  = 1'b1;
    result.rob        = pkt.w_rob;
    result.arch_reg   = pkt.arch_dest;
    result.phys_reg   = pkt.p_dest;
    result.data       = res;
    result.ps1_rdata  = a;
    result.ps2_rdata  = b;
    result.branch_imm = pkt.imm_gen;
    result.is_branch  = (pkt.opcode == op_b_jal) || (pkt.opcode == op_b_jalr) ||
                        ((pkt.opcode == op_b_br) && res[0]);
    result.is_jalr    = (pkt.opcode == op_b_jalr);
  end

endmodule

// File: rtl/alu_cmp_q.sv
// ALU/compare functional unit with an OUT_DEPTH-entry in-order result queue to the CDB arbiter.
// Define ALU_CMP_Q_STATS_EN to build the saturating stall_cnt/busy_cnt counters.
module alu_cmp_q
  import alu_cmp_q_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = $clog2(OUT_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  ReservationEntry_t    in_pkt,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output cdb_t                 cdb_output,
  output logic [CNT_W-1:0]     occupancy,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          busy_cnt
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

  cdb_t             exec_out;
  cdb_t             mem [OUT_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push;
  logic             pop;

  alu_cmp_exec u_exec (
    .pkt    (in_pkt),
    .a      (a),
    .b      (b),
    .result (exec_out)
  );

  assign push = in_valid && in_ready_r;
  assign pop  = out_valid_r && out_ready;

  // Next occupancy; flush wins over any push or pop in the same cycle
  always_comb begin
    if (flush) begin
      count_next = {CNT_W{1'b0}};
    end else begin
      count_next = count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointers, count and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r     <= count_next;
      in_ready_r  <= (count_next != FULL_CNT);
      out_valid_r <= (count_next != {CNT_W{1'b0}});
    end
  end

  // Queue storage; contents are meaningless unless covered by count
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail_r] <= exec_out;
    end
  end

  // Head presentation, zeroed while empty
  always_comb begin
    if (out_valid_r) begin
      cdb_output = mem[head_r];
    end else begin
      cdb_output = '0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign occupancy = count_r;

`ifdef ALU_CMP_Q_STATS_EN
  logic [31:0] stall_r;
  logic [31:0] busy_r;

  // Saturating stall/busy counters; survive flush, cleared by reset only
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= 32'd0;
      busy_r  <= 32'd0;
    end else begin
      if (in_valid && !in_ready_r && (stall_r != 32'hFFFF_FFFF)) begin
        stall_r <= stall_r + 32'd1;
      end
      if (out_valid_r && !out_ready && (busy_r != 32'hFFFF_FFFF)) begin
        busy_r <= busy_r + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_r;
  assign busy_cnt  = busy_r;
`else
  assign stall_cnt = 32'd0;
  assign busy_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_alu_cmp_q.sv
// Scoreboard bench for alu_cmp_q: expected CDB packets are queued on issue and compared at the head.
// Stats checks follow ALU_CMP_Q_STATS_EN.
module tb_alu_cmp_q;
  import alu_cmp_q_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  ReservationEntry_t in_pkt;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  cdb_t              cdb_output;
  logic [CW-1:0]     occupancy;
  logic [31:0]       stall_cnt;
  logic [31:0]       busy_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          seq      = 0;
  cdb_t        sb [$];
  cdb_t        exp_cur;
  logic        mon_en   = 1'b0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_busy  = 32'd0;

  alu_cmp_q #(.OUT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pkt     (in_pkt),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cdb_output (cdb_output),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic alu_cmp_op_t mk_op(input logic is_alu, input logic [2:0] f3);
    alu_cmp_op_t o;
    o.is_alu = is_alu;
    o.funct3 = f3;
    return o;
  endfunction

  // Present one op on the issue port together with its expected CDB packet
  task automatic present(input alu_cmp_op_t op, input logic [6:0] opc, input logic [31:0] imm,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] data,
                         input logic br, input logic jr);
    ReservationEntry_t p;
    cdb_t e;
    seq++;
    p.op        = op;
    p.opcode    = opc;
    p.imm_gen   = imm;
    p.arch_dest = 5'(seq);
    p.p_dest    = PR_WIDTH'(seq * 3);
    p.w_rob     = ROB_WIDTH'(seq);
    e            = '0;
    e.cdb_valid  = 1'b1;
    e.rob        = p.w_rob;
    e.arch_reg   = p.arch_dest;
    e.phys_reg   = p.p_dest;
    e.data       = data;
    e.ps1_rdata  = va;
    e.ps2_rdata  = vb;
    e.branch_imm = imm;
    e.is_branch  = br;
    e.is_jalr    = jr;
    in_pkt   = p;
    a        = va;
    b        = vb;
    exp_cur  = e;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle monitor: compare DUT state with the scoreboard, then apply this cycle's handshakes
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check_eq("occupancy", 256'(occupancy), 256'(sb.size()));
      check_eq("in_ready", 256'(in_ready), 256'(sb.size() != DEPTH));
      check_eq("out_valid", 256'(out_valid), 256'(sb.size() != 0));
      if (sb.size() == 0) begin
        check_eq("cdb_idle", 256'(cdb_output), 256'(0));
      end else begin
        check_eq("cdb_head", 256'(cdb_output), 256'(sb[0]));
      end
`ifdef ALU_CMP_Q_STATS_EN
      check_eq("stall_cnt", 256'(stall_cnt), 256'(exp_stall));
      check_eq("busy_cnt", 256'(busy_cnt), 256'(exp_busy));
      if (in_valid && sb.size() == DEPTH) exp_stall = exp_stall + 32'd1;
      if (sb.size() != 0 && !out_ready) exp_busy = exp_busy + 32'd1;
`else
      check_eq("stall_cnt", 256'(stall_cnt), 256'(0));
      check_eq("busy_cnt", 256'(busy_cnt), 256'(0));
`endif
      if (flush) begin
        sb.delete();
      end else begin
        automatic bit can_push = in_valid && (sb.size() != DEPTH);
        if (out_ready && sb.size() != 0) void'(sb.pop_front());
        if (can_push) sb.push_back(exp_cur);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pkt = '0; a = 32'd0; b = 32'd0; exp_cur = '0;
    tick();
    tick();
    check_eq("rst_out_valid", 256'(out_valid), 256'(0));
    check_eq("rst_in_ready", 256'(in_ready), 256'(1));
    check_eq("rst_occupancy", 256'(occupancy), 256'(0));
    check_eq("rst_cdb", 256'(cdb_output), 256'(0));
    check_eq("rst_stall", 256'(stall_cnt), 256'(0));
    check_eq("rst_busy", 256'(busy_cnt), 256'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // Back-to-back issue with the arbiter always ready
    out_ready = 1'b1;
    present(mk_op(1'b1, alu_add), op_b_reg, 32'h0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_sub), op_b_reg, 32'h0, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    tick(); tick();

    // Fill the queue with the arbiter stalled, then offer a fifth op that must wait
    out_ready = 1'b0;
    present(mk_op(1'b0, blt), op_b_br, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0); tick();
    present(mk_op(1'b0, bltu), op_b_br, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_add), op_b_jalr, 32'h8, 32'h1000, 32'h20, 32'h28, 1'b1, 1'b1); tick();
    present(mk_op(1'b1, alu_sra), op_b_reg, 32'h0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_add), op_b_lui, 32'h1234_5000, 32'hDEAD, 32'hBEEF, 32'h1234_5000, 1'b0, 1'b0);
    tick(); tick();
    in_valid = 1'b0;

    // Single pop from full, then push+pop together across pointer wrap
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1;
    present(mk_op(1'b1, alu_add), op_b_lui, 32'h1234_5000, 32'hDEAD, 32'hBEEF, 32'h1234_5000, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_xor), op_b_imm, 32'h0FF0, 32'hF0F0, 32'h1234, 32'hFF00, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_srl), op_b_reg, 32'h0, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b0); tick();
    present(mk_op(1'b0, 3'b010), op_b_br, 32'h4, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0); tick();
    present(mk_op(1'b0, bgeu), op_b_br, 32'h4, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_add), op_b_auipc, 32'h1000, 32'h55, 32'h66, 32'h1000, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_sll), op_b_reg, 32'h0, 32'd1, 32'h1F, 32'h8000_0000, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_and), op_b_reg, 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0); tick();
    present(mk_op(1'b1, alu_add), op_b_jal, 32'h40, 32'h77, 32'h0, 32'h40, 1'b1, 1'b0); tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();

    // Flush with three queued and a simultaneous issue
    out_ready = 1'b0;
    present(mk_op(1'b0, beq), op_b_br, 32'h8, 32'd7, 32'd7, 32'd1, 1'b1, 1'b0); tick();
    present(mk_op(1'b0, bne), op_b_br, 32'h8, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0); tick();
    present(mk_op(1'b0, bge), op_b_br, 32'h8, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0); tick();
    present(mk_op(1'b1, alu_add), op_b_reg, 32'h0, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_occupancy", 256'(occupancy), 256'(0));
    check_eq("flush_out_valid", 256'(out_valid), 256'(0));
    check_eq("flush_cdb", 256'(cdb_output), 256'(0));
    tick();
    out_ready = 1'b1;
    present(mk_op(1'b1, alu_or), op_b_imm, 32'h00F0, 32'h0F00, 32'h9999, 32'h0FF0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("final_empty", 256'(occupancy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmp_q.md
Name: alu_cmp_q

Overview:
- Parametrised integer ALU/compare functional unit with an OUT_DEPTH-entry result queue between execute and the CDB arbiter.
- Replaces the single-latch scheme: the reservation station issues back-to-back while the arbiter is busy, and stalls only when the queue is full.
- Adds a branch-mispredict flush.
- Sits between the ALU reservation station and the CDB arbiter.

Parameters:
- OUT_DEPTH, 4, result queue entries; power of two, ≥2.
- CNT_W, $clog2(OUT_DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict flush; discards all queued and in-flight results
- in_valid  in  1  issue handshake valid from RS
- in_ready  out  1  issue handshake ready to RS
- in_pkt  in  ReservationEntry_t  Op, opcode, imm_gen, archDest, pDest, Wrob
- a, b  in  32 each  rs1/rs2 operand values
- out_valid  out  1  head entry valid to arbiter
- out_ready  in  1  arbiter accepts head this cycle
- cdb_output  out  cdb_t  head entry packaged for CDB
- occupancy  out  CNT_W  entries currently queued
- stall_cnt  out  32  cycles with in_valid && !in_ready (ALU_CMP_Q_STATS_EN only)
- busy_cnt  out  32  cycles with out_valid && !out_ready (ALU_CMP_Q_STATS_EN only)

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high. Polarity and synchronicity are fixed.
- Reset: queue empty, head/tail/count = 0. Outputs: out_valid=0, cdb_output all-zero, occupancy=0, in_ready=1, stall_cnt=0, busy_cnt=0.
- Issue fires on in_valid && in_ready.
- in_ready = (count != OUT_DEPTH). It is a registered function of count only; there is no combinational path from out_ready.
- Operand select:
  - jal/jalr: A=imm_gen.
  - lui/auipc: A=0, B=imm_gen.
  - op_b_imm: B=imm_gen.
  - op_b_reg shifts (srl/sra): B={27'b0,b[4:0]}.
  - Otherwise A=a, B=b.
- Op[3]=1 selects ALU by Op[2:0]: add, sll, sra, sub, xor, srl, or, and.
  - Shifts use B[4:0].
  - sra is arithmetic.
  - All arithmetic is mod 2^32.
- Op[3]=0 selects compare by Op[2:0]: beq, bne, blt, bge, bltu, bgeu.
  - Result is {31'b0, cmp}.
  - Undefined funct3 gives result 0.
- is_branch = opcode in {jal, jalr} || (opcode==br && result[0]).
- is_jalr = (opcode==jalr).
- Entry on fire: cdb_valid=1, rob=Wrob, arch_reg=archDest, phys_reg=pDest, data=result, ps1_rdata=a, ps2_rdata=b, branch_imm=imm_gen, is_branch, is_jalr.
- All other cdb_t fields are hard 0 (is_store, mem_addr, mem_wdata, mem_rdata, mem_rmask, mem_wmask).
- Latency: an issue fire at cycle N makes the entry visible at the head in cycle N+1 at earliest, never in the same cycle.
- out_valid = (count != 0).
- When out_valid=0, cdb_output is all-zero, including cdb_valid.
- When out_valid=1, cdb_output shows the head entry and is held stable until out_ready.
- Pop happens on out_valid && out_ready. An in-order FIFO, so cdb order equals issue order.
- Simultaneous push and pop: count is unchanged. This is legal at any count < OUT_DEPTH.
- When full with a pop in the same cycle: in_ready is still 0, so there is no push that cycle.
- Pointers wrap modulo OUT_DEPTH.
- Flush: next cycle, count=0, head=tail, out_valid=0.
  - Flush has priority over a push or pop in the same cycle; that push is dropped and the pop is ignored.
  - The arbiter must not latch the head when flush=1.
- rst has priority over flush. Reset mid-operation discards all entries.
- Queue storage needs no reset; only the pointers and count do.

Optional Feature:
- Macro ALU_CMP_Q_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with in_valid && !in_ready.
  - busy_cnt increments each cycle with out_valid && !out_ready.
  - Both saturate at 2^32-1.
  - Both clear on rst only, not on flush.
- Undefined: both ports are tied to 0 and no counter flops are generated. Ports are present in both builds.

Decomposition:
- rv32i_types carries ReservationEntry_t, cdb_t, the alu_ops and branch_funct3 enums, the op_b_* opcodes, PR_WIDTH and ROB_WIDTH.
- Add an alu_cmp_op_t typedef for the 4-bit {is_alu, funct3} field.
- Sub-module alu_cmp_exec: purely combinational operand select + ALU/CMP + branch flags, producing a cdb_t.
- The top holds the queue, handshake, flush and counters.

Test Plan:
- Back-to-back: issue add a=5,b=7 then sub a=3,b=10 with out_ready=1 → data 12, then 0xFFFFFFF9, on consecutive cycles, each one cycle after its issue.
- Fill: out_ready=0, issue 4 ops → occupancy=4, in_ready=0. A 5th in_valid is not accepted; stall_cnt increments with STATS_EN.
- Full + pop: count=4, out_ready=1 for one cycle → next cycle count=3, in_ready=1. Then push+pop together → count holds at 3. FIFO order is preserved across pointer wrap.
- Compare/branch: opcode=br blt a=0xFFFFFFFF, b=1 → data=1, is_branch=1. bltu with the same operands → data=0, is_branch=0. jalr → is_branch=1, is_jalr=1.
- Shift/imm: op_b_reg sra a=0x80000000, b=0x24 → 0xF8000000 (shift 4). lui imm=0x12345000 → data=0x12345000.
- Flush: 3 queued, flush=1 with simultaneous in_valid → next cycle out_valid=0, occupancy=0, cdb_output all-zero. The flushed-cycle issue is absent afterwards.
